// File: rtl/slice_stream.sv
// slice_stream: bit slicer between the input DMA word stream and branch-metric
// calculation. Buffers DATA_W-bit words MSB-first, cuts them into 2- or 3-bit
// received symbols, and emits SYM_PER_CYC symbols per beat with a lane mask,
// counting symbols against a programmed frame length.
module slice_stream #(
   parameter int DATA_W      = 16,
   parameter int SYM_PER_CYC = 2,
   parameter int BUF_W       = 32,
   parameter int LEN_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_s,
   input  logic                       i_start,
   input  logic                       i_code_rate,
   input  logic [LEN_W-1:0]           i_frame_len,
   input  logic                       i_data_valid,
   input  logic [DATA_W-1:0]          i_data_frame,
   output logic                       o_data_ready,
   output logic [3*SYM_PER_CYC-1:0]   o_rx,
   output logic [SYM_PER_CYC-1:0]     o_rx_mask,
   output logic                       o_rx_valid,
   input  logic                       i_rx_ready,
   output logic                       o_ood,
   output logic                       o_busy
);

   localparam int FILL_W = $clog2(BUF_W + 1);
   localparam int SYM_W  = $clog2(SYM_PER_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                     state_q;
   logic                       rate_q;
   logic [LEN_W-1:0]           remain_q;
   logic [BUF_W-1:0]           buf_q, buf_d;
   logic [FILL_W-1:0]          fill_q, fill_d;
   logic [3*SYM_PER_CYC-1:0]   rx_q, rx_d;
   logic [SYM_PER_CYC-1:0]     mask_q, mask_d;
   logic                       rx_valid_q;
   logic                       ood_q;

   logic [SYM_W-1:0]           nsym;
   logic [FILL_W-1:0]          need_bits;
   logic [FILL_W-1:0]          consume;
   logic                       active;
   logic                       accept;
   logic                       load;
   logic                       last_taken;

   // Beat size and bit cost: the last beat of a frame may carry fewer symbols.
   always_comb begin
      if (remain_q >= LEN_W'(SYM_PER_CYC)) nsym = SYM_W'(SYM_PER_CYC);
      else                                 nsym = SYM_W'(remain_q);
      need_bits = rate_q ? FILL_W'(nsym) * FILL_W'(3) : FILL_W'(nsym) * FILL_W'(2);
   end

   // A start pulse owns its cycle, so no data moves while one is present.
   assign active       = en_s && !i_start && (state_q == S_RUN);
   assign o_data_ready = active && (fill_q <= FILL_W'(BUF_W - DATA_W));
   assign accept       = o_data_ready && i_data_valid;
   assign load         = active && (remain_q != '0) && (fill_q >= need_bits) &&
                         (!rx_valid_q || i_rx_ready);
   assign last_taken   = active && (remain_q == '0) && rx_valid_q && i_rx_ready;

   // Bit buffer: earliest bit sits at the MSB; consume from the top, append below fill.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      consume = load ? need_bits : '0;
      buf_d   = buf_q << consume;
      fill_d  = fill_q - consume;
      if (accept) begin
         buf_d  = buf_d | ({i_data_frame, {(BUF_W-DATA_W){1'b0}}} >> fill_d);
         fill_d = fill_d + FILL_W'(DATA_W);
      end
   end

   // Beat formation: lane k takes symbol k, earliest bit into the lane LSB.
   always_comb begin
      rx_d   = '0;
      mask_d = '0;
      for (int k = 0; k < SYM_PER_CYC; k++) begin
         if (SYM_W'(k) < nsym) begin
            mask_d[k] = 1'b1;
            for (int b = 0; b < 3; b++) begin
               if (rate_q)     rx_d[3*k+b] = buf_q[BUF_W-1-3*k-b];
               else if (b < 2) rx_d[3*k+b] = buf_q[BUF_W-1-2*k-b];
            end
         end
      end
   end

   // Control FSM plus all state and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state_q    <= S_IDLE;
         rate_q     <= 1'b0;
         remain_q   <= '0;
         // NOTE: the bit buffer is a plain register, not a RAM, so clearing it
         // on reset is cheap and keeps stale bits out of the first frame.
         buf_q      <= '0;
         fill_q     <= '0;
         rx_q       <= '0;
         mask_q     <= '0;
         rx_valid_q <= 1'b0;
         ood_q      <= 1'b0;
      end else if (en_s) begin
         if (i_start) begin
            rate_q     <= i_code_rate;
            remain_q   <= i_frame_len;
            buf_q      <= '0;
            fill_q     <= '0;
            rx_q       <= '0;
            mask_q     <= '0;
            rx_valid_q <= 1'b0;
            if (i_frame_len == '0) begin
               state_q <= S_DONE;
               ood_q   <= 1'b1;
            end else begin
               state_q <= S_RUN;
               ood_q   <= 1'b0;
            end
         end else begin
            case (state_q)
               S_RUN: begin
                  buf_q  <= buf_d;
                  fill_q <= fill_d;
                  if (load) begin
                     rx_q       <= rx_d;
                     mask_q     <= mask_d;
                     rx_valid_q <= 1'b1;
                     remain_q   <= remain_q - LEN_W'(nsym);
                  end else if (i_rx_ready) begin
                     rx_valid_q <= 1'b0;
                  end
                  if (last_taken) begin
                     state_q <= S_DONE;
                     ood_q   <= 1'b1;
                     buf_q   <= '0;
                     fill_q  <= '0;
                  end
               end
               default: ;  // IDLE and DONE only leave on i_start
            endcase
         end
      end
   end

   assign o_rx       = rx_q;
   assign o_rx_mask  = mask_q;
   assign o_rx_valid = rx_valid_q;
   assign o_ood      = ood_q;
   assign o_busy     = (state_q == S_RUN);

endmodule

// File: tb/tb_slice_stream.sv
// tb_slice_stream: table-driven frame vectors plus hand-written sequences for
// zero-length frames, enable freeze, mid-frame abort and mid-frame reset.
module tb_slice_stream;

   logic        clk;
   logic        rst;
   logic        en_s;
   logic        i_start;
   logic        i_code_rate;
   logic [15:0] i_frame_len;
   logic        i_data_valid;
   logic [15:0] i_data_frame;
   logic        o_data_ready;
   logic [5:0]  o_rx;
   logic [1:0]  o_rx_mask;
   logic        o_rx_valid;
   logic        i_rx_ready;
   logic        o_ood;
   logic        o_busy;

   int checks = 0;
   int errors = 0;

   slice_stream #(
      .DATA_W(16), .SYM_PER_CYC(2), .BUF_W(32), .LEN_W(16)
   ) dut (
      .clk(clk), .rst(rst), .en_s(en_s), .i_start(i_start),
      .i_code_rate(i_code_rate), .i_frame_len(i_frame_len),
      .i_data_valid(i_data_valid), .i_data_frame(i_data_frame),
      .o_data_ready(o_data_ready), .o_rx(o_rx), .o_rx_mask(o_rx_mask),
      .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
      .o_ood(o_ood), .o_busy(o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rate;
      logic [15:0]      len;
      int               nwords;
      logic [3:0][15:0] words;
      int               nbeats;
      logic [15:0][5:0] rx;
      logic [15:0][1:0] mask;
      int               hold;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic new_vec(input int i, input logic rate, input logic [15:0] len, input int hold);
      vecs[i].rate   = rate;
      vecs[i].len    = len;
      vecs[i].hold   = hold;
      vecs[i].nwords = 0;
      vecs[i].nbeats = 0;
      vecs[i].words  = '0;
      vecs[i].rx     = '0;
      vecs[i].mask   = '0;
   endtask

   task automatic add_word(input int i, input logic [15:0] w);
      vecs[i].words[vecs[i].nwords] = w;
      vecs[i].nwords++;
   endtask

   task automatic add_beat(input int i, input logic [5:0] rx, input logic [1:0] m);
      vecs[i].rx[vecs[i].nbeats]   = rx;
      vecs[i].mask[vecs[i].nbeats] = m;
      vecs[i].nbeats++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx"},       32'(o_rx), 32'h0);
      check({tag, "_mask"},     32'(o_rx_mask), 32'h0);
      check({tag, "_rx_valid"}, 32'(o_rx_valid), 32'h0);
      check({tag, "_ood"},      32'(o_ood), 32'h0);
      check({tag, "_busy"},     32'(o_busy), 32'h0);
      check({tag, "_ready"},    32'(o_data_ready), 32'h0);
   endtask

   // Called and returns just after a falling edge.
   task automatic run_frame(input vec_t v, input bit do_start, input int first_word);
      int wi;
      int bi;
      int hold_left;
      bit acc;
      bit beat;
      wi        = first_word;
      bi        = 0;
      hold_left = v.hold;
      if (do_start) begin
         i_start      = 1'b1;
         i_code_rate  = v.rate;
         i_frame_len  = v.len;
         i_data_valid = 1'b1;        // must not be taken on the start cycle
         i_data_frame = 16'hDEAD;
         i_rx_ready   = 1'b1;
         @(negedge clk);
         i_start      = 1'b0;
         i_code_rate  = ~v.rate;     // configuration must be ignored now
         i_frame_len  = 16'hFFFF;
      end
      for (int cyc = 0; cyc < 200 && bi < v.nbeats; cyc++) begin
         i_data_valid = (wi < v.nwords);
         i_data_frame = (wi < v.nwords && wi < 4) ? v.words[wi] : 16'h0000;
         i_rx_ready   = (hold_left == 0);
         #1;
         acc  = i_data_valid && o_data_ready;
         beat = o_rx_valid && i_rx_ready;
         if (o_rx_valid) begin
            check("beat_rx", 32'(o_rx), 32'(v.rx[bi]));
            check("beat_mask", 32'(o_rx_mask), 32'(v.mask[bi]));
            if (hold_left > 0) begin
               if (hold_left == 1) begin
                  check("bp_ready_low", 32'(o_data_ready), 32'h0);
                  check("bp_words_taken", 32'(wi), 32'd2);
               end
               hold_left--;
            end
         end
         @(negedge clk);
         if (acc)  wi++;
         if (beat) bi++;
      end
      i_data_valid = 1'b0;
      check("beat_count", 32'(bi), 32'(v.nbeats));
      check("end_ood", 32'(o_ood), 32'h1);
      check("end_busy", 32'(o_busy), 32'h0);
      check("end_rx_valid", 32'(o_rx_valid), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Rate 1/2, one word, four full beats.
      new_vec(0, 1'b0, 16'd8, 0);
      add_word(0, 16'hB4C3);
      add_beat(0, 6'b011001, 2'b11);
      add_beat(0, 6'b000010, 2'b11);
      add_beat(0, 6'b000011, 2'b11);
      add_beat(0, 6'b011000, 2'b11);
      // Rate 1/3, partial last beat, one leftover bit dropped.
      new_vec(1, 1'b1, 16'd5, 0);
      add_word(1, 16'hFFFF);
      add_beat(1, 6'b111111, 2'b11);
      add_beat(1, 6'b111111, 2'b11);
      add_beat(1, 6'b000111, 2'b01);
      // Rate 1/2, odd length: 0010 1100 ... -> {00,01},{11}.
      new_vec(2, 1'b0, 16'd3, 0);
      add_word(2, 16'h2C00);
      add_beat(2, 6'b001000, 2'b11);
      add_beat(2, 6'b000011, 2'b01);
      // Rate 1/3 across word boundaries: bits 15,16,17 = 0,1,1 -> lane1 = 3'b110.
      new_vec(3, 1'b1, 16'd11, 0);
      add_word(3, 16'h0000);
      add_word(3, 16'hFFFF);
      add_word(3, 16'hFFFF);
      add_beat(3, 6'b000000, 2'b11);
      add_beat(3, 6'b000000, 2'b11);
      add_beat(3, 6'b110000, 2'b11);
      add_beat(3, 6'b111111, 2'b11);
      add_beat(3, 6'b111111, 2'b11);
      add_beat(3, 6'b000111, 2'b01);
      // Backpressure: first beat held 5 cycles, then 16 beats drain.
      new_vec(4, 1'b0, 16'd32, 5);
      for (int w = 0; w < 4; w++) begin
         add_word(4, 16'hB4C3);
         add_beat(4, 6'b011001, 2'b11);
         add_beat(4, 6'b000010, 2'b11);
         add_beat(4, 6'b000011, 2'b11);
         add_beat(4, 6'b011000, 2'b11);
      end

      rst          = 1'b0;
      en_s         = 1'b1;
      i_start      = 1'b0;
      i_code_rate  = 1'b0;
      i_frame_len  = 16'd0;
      i_data_valid = 1'b1;
      i_data_frame = 16'hFFFF;
      i_rx_ready   = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst          = 1'b1;
      i_data_valid = 1'b0;
      @(negedge clk);

      // Zero-length frame goes straight to DONE.
      i_start     = 1'b1;
      i_frame_len = 16'd0;
      @(negedge clk);
      i_start = 1'b0;
      check("len0_ood", 32'(o_ood), 32'h1);
      check("len0_rx_valid", 32'(o_rx_valid), 32'h0);
      check("len0_busy", 32'(o_busy), 32'h0);
      @(negedge clk);
      check("len0_rx_valid_later", 32'(o_rx_valid), 32'h0);

      for (int i = 0; i < 5; i++) run_frame(vecs[i], 1'b1, 0);

      // Enable freeze with a beat pending and a word offered.
      i_start     = 1'b1;
      i_code_rate = 1'b0;
      i_frame_len = 16'd8;
      i_rx_ready  = 1'b0;
      @(negedge clk);
      i_start      = 1'b0;
      i_data_valid = 1'b1;
      i_data_frame = 16'hB4C3;
      @(negedge clk);
      i_data_valid = 1'b0;
      @(negedge clk);
      check("pre_freeze_valid", 32'(o_rx_valid), 32'h1);
      en_s         = 1'b0;
      i_rx_ready   = 1'b1;
      i_data_valid = 1'b1;
      i_data_frame = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("freeze_ready", 32'(o_data_ready), 32'h0);
         @(negedge clk);
         check("freeze_rx", 32'(o_rx), 32'(6'b011001));
         check("freeze_mask", 32'(o_rx_mask), 32'(2'b11));
         check("freeze_valid", 32'(o_rx_valid), 32'h1);
         check("freeze_busy", 32'(o_busy), 32'h1);
         check("freeze_ood", 32'(o_ood), 32'h0);
      end
      en_s         = 1'b1;
      i_data_valid = 1'b0;
      run_frame(vecs[0], 1'b0, 1);

      // Abort a rate-1/3 frame mid-beat and restart at rate 1/2.
      i_start     = 1'b1;
      i_code_rate = 1'b1;
      i_frame_len = 16'd5;
      i_rx_ready  = 1'b0;
      @(negedge clk);
      i_start      = 1'b0;
      i_data_valid = 1'b1;
      i_data_frame = 16'hFFFF;
      @(negedge clk);
      i_data_valid = 1'b0;
      @(negedge clk);
      check("abort_pending_rx", 32'(o_rx), 32'(6'b111111));
      i_start      = 1'b1;
      i_code_rate  = 1'b0;
      i_frame_len  = 16'd8;
      i_data_valid = 1'b1;
      #1;
      check("start_cycle_ready", 32'(o_data_ready), 32'h0);
      @(negedge clk);
      i_start      = 1'b0;
      i_data_valid = 1'b0;
      check("abort_rx_valid", 32'(o_rx_valid), 32'h0);
      check("abort_busy", 32'(o_busy), 32'h1);
      check("abort_ood", 32'(o_ood), 32'h0);
      run_frame(vecs[0], 1'b0, 0);

      // Reset in the middle of a frame.
      i_start     = 1'b1;
      i_code_rate = 1'b1;
      i_frame_len = 16'd5;
      i_rx_ready  = 1'b0;
      @(negedge clk);
      i_start      = 1'b0;
      i_data_valid = 1'b1;
      i_data_frame = 16'hFFFF;
      @(negedge clk);
      i_data_valid = 1'b0;
      @(negedge clk);
      check("prereset_valid", 32'(o_rx_valid), 32'h1);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      rst          = 1'b1;
      i_data_valid = 1'b1;
      #1;
      check("idle_ready", 32'(o_data_ready), 32'h0);
      @(negedge clk);
      i_data_valid = 1'b0;
      check("idle_busy", 32'(o_busy), 32'h0);
      check("idle_rx_valid", 32'(o_rx_valid), 32'h0);
      run_frame(vecs[0], 1'b1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
